// File: rtl/tx_stream_pkg.sv
// tx_stream_pkg: shared FSM/speed encodings, bucket sizing constants and a popcount helper
package tx_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XMIT = 2'd1, DROP = 2'd2} tx_state_e;
  typedef enum logic [1:0] {SPD_10M = 2'd0, SPD_100M = 2'd1, SPD_1G = 2'd2, SPD_10G = 2'd3} tx_speed_e;
  localparam int TICK_BITS = 10;
  localparam int CREDIT_W = 20;
  function automatic logic [6:0] popcount(input logic [63:0] v);
    popcount = '0;
    for (int i = 0; i < 64; i++) popcount += 7'(v[i]);
  endfunction
endpackage

// File: rtl/tx_token_bucket.sv
// tx_token_bucket: 1024-cycle tick, signed byte credit with saturation; ports: i_clk, i_rst, i_cfg (shape cfg), i_sub_en/i_sub_keep (forwarded beat), o_credit_ok
module tx_token_bucket import tx_stream_pkg::*; #(
  parameter int KEEP_W = 4,
  parameter int CREDIT_MAX = 16383
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_cfg,
  input  logic              i_sub_en,
  input  logic [KEEP_W-1:0] i_sub_keep,
  output logic              o_credit_ok
);
  localparam logic signed [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);
  logic [TICK_BITS-1:0] tick_q;
  logic signed [CREDIT_W-1:0] credit_q, credit_d, add, sub, sum;
  always_comb begin
    add = &tick_q ? CREDIT_W'(i_cfg[14:0]) : '0;
    sub = i_sub_en ? CREDIT_W'(popcount(64'(i_sub_keep))) : '0;
    sum = credit_q + add - sub;
    credit_d = !i_cfg[15] ? CMAX : (sum > CMAX ? CMAX : sum);
    o_credit_ok = !i_cfg[15] | !credit_q[CREDIT_W-1];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_q <= '0;
      credit_q <= '0;
    end else begin
      tick_q <= tick_q + 1'b1;
      credit_q <= credit_d;
    end
  end
endmodule

// File: rtl/tx_byte_stream_ctrl.sv
// tx_byte_stream_ctrl: egress frame shaper/link-drop filter with registered MAC stage and TX stats; cross_tx_* in, mac_tx_* out, shape cfg, byte/frame counters; TX_STREAM_CRCERR_CNT_EN adds o_port_tx_crcerr_cnt
module tx_byte_stream_ctrl import tx_stream_pkg::*; #(
  parameter int PORT_NUM = 4,
  parameter int PORT_MNG_DATA_WIDTH = 8,
  parameter int CROSS_DATA_WIDTH = PORT_MNG_DATA_WIDTH * PORT_NUM,
  parameter int CREDIT_MAX = 16383,
  localparam int KEEP_W = CROSS_DATA_WIDTH / 8,
  localparam int DW = CROSS_DATA_WIDTH + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_port_shape_cfg_regs,
  output logic [15:0]       o_port_tx_byte_cnt,
  output logic [15:0]       o_port_tx_frame_cnt,
`ifdef TX_STREAM_CRCERR_CNT_EN
  output logic [15:0]       o_port_tx_crcerr_cnt,
`endif
  input  logic              i_tx_port_link,
  input  logic [1:0]        i_tx_port_speed,
  input  logic [DW-1:0]     i_cross_tx_axi_data,
  input  logic [KEEP_W-1:0] i_cross_tx_axi_data_keep,
  input  logic              i_cross_tx_axi_data_valid,
  output logic              o_cross_tx_axi_data_ready,
  input  logic              i_cross_tx_axi_data_last,
  output logic              o_mac_tx_port_link,
  output logic [1:0]        o_mac_tx_port_speed,
  output logic [DW-1:0]     o_mac_tx_axi_data,
  output logic [KEEP_W-1:0] o_mac_tx_axi_data_keep,
  output logic              o_mac_tx_axi_data_valid,
  input  logic              i_mac_tx_axi_data_ready,
  output logic              o_mac_tx_axi_data_last
);
  tx_state_e state_q, state_d;
  logic pipe_rdy, credit_ok, idle_go, rdy, acc, fwd, cut, dlv;
  logic [DW-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic valid_q, last_q, link_q;
  logic [1:0] speed_q;
  logic [15:0] byte_q, frame_q;
  tx_token_bucket #(.KEEP_W(KEEP_W), .CREDIT_MAX(CREDIT_MAX)) u_bucket (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cfg(i_port_shape_cfg_regs),
    .i_sub_en(fwd),
    .i_sub_keep(i_cross_tx_axi_data_keep),
    .o_credit_ok(credit_ok)
  );
  // A beat accepted while the link is down mid-frame becomes a forced errored last beat.
  always_comb begin
    pipe_rdy = !valid_q | i_mac_tx_axi_data_ready;
    idle_go = i_cross_tx_axi_data_valid & i_tx_port_link & credit_ok;
    rdy = state_q == DROP ? 1'b1 : state_q == XMIT ? pipe_rdy : idle_go & pipe_rdy;
    acc = i_cross_tx_axi_data_valid & rdy;
    fwd = acc & (state_q != DROP);
    cut = fwd & !i_tx_port_link;
    dlv = valid_q & i_mac_tx_axi_data_ready;
    state_d = state_q == IDLE ? (i_cross_tx_axi_data_valid & !i_tx_port_link ? DROP :
                                 idle_go & !(acc & i_cross_tx_axi_data_last) ? XMIT : IDLE) :
              state_q == XMIT ? (acc & i_cross_tx_axi_data_last ? IDLE : cut ? DROP : XMIT) :
                                (acc & i_cross_tx_axi_data_last ? IDLE : DROP);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q <= '0;
      keep_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      link_q <= 1'b0;
      speed_q <= '0;
      byte_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      link_q <= i_tx_port_link;
      speed_q <= i_tx_port_speed;
      if (pipe_rdy) valid_q <= fwd;
      if (fwd) begin
        data_q <= {i_cross_tx_axi_data[DW-1] | cut, i_cross_tx_axi_data[DW-2:0]};
        keep_q <= i_cross_tx_axi_data_keep;
        last_q <= i_cross_tx_axi_data_last | cut;
      end
      if (dlv) begin
        byte_q <= byte_q + 16'(popcount(64'(keep_q)));
        frame_q <= frame_q + 16'(last_q);
      end
    end
  end
`ifdef TX_STREAM_CRCERR_CNT_EN
  logic [15:0] crc_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) crc_q <= '0;
    else if (dlv & last_q & data_q[DW-1]) crc_q <= crc_q + 16'd1;
  end
  assign o_port_tx_crcerr_cnt = crc_q;
`else
`endif
  assign o_cross_tx_axi_data_ready = rdy;
  assign o_mac_tx_port_link = link_q;
  assign o_mac_tx_port_speed = speed_q;
  assign o_mac_tx_axi_data = data_q;
  assign o_mac_tx_axi_data_keep = keep_q;
  assign o_mac_tx_axi_data_valid = valid_q;
  assign o_mac_tx_axi_data_last = last_q;
  assign o_port_tx_byte_cnt = byte_q;
  assign o_port_tx_frame_cnt = frame_q;
endmodule

// File: tb/tb_tx_byte_stream_ctrl.sv
// tb_tx_byte_stream_ctrl: randomized scoreboard bench for tx_byte_stream_ctrl
module tb_tx_byte_stream_ctrl;
  typedef struct packed {logic [32:0] d; logic [3:0] k; logic l;} beat_t;
  logic clk = 0, rst = 1, link = 1, vld = 0, lst = 0, rdy, mrdy = 1;
  logic [15:0] cfg = 0, byte_cnt, frame_cnt;
  logic [1:0] spd = 0, mspd, pspd;
  logic [32:0] din = 0, dout;
  logic [3:0] kin = 0, kout;
  logic ov, olast, mlink, plink, prst = 1, pv = 0, pm = 0;
`ifdef TX_STREAM_CRCERR_CNT_EN
  logic [15:0] crc_cnt;
`endif
  beat_t sb[$];
  beat_t pb, mb;
  int checks = 0, errs = 0, mode = 0, fwd_bytes = 0, rmode = 0;
  longint cyc = 0;
  bit shape_chk = 0;
  logic [15:0] eb = 0, ef = 0, ec = 0;

  tx_byte_stream_ctrl dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_port_shape_cfg_regs(cfg),
    .o_port_tx_byte_cnt(byte_cnt),
    .o_port_tx_frame_cnt(frame_cnt),
`ifdef TX_STREAM_CRCERR_CNT_EN
    .o_port_tx_crcerr_cnt(crc_cnt),
`endif
    .i_tx_port_link(link),
    .i_tx_port_speed(spd),
    .i_cross_tx_axi_data(din),
    .i_cross_tx_axi_data_keep(kin),
    .i_cross_tx_axi_data_valid(vld),
    .o_cross_tx_axi_data_ready(rdy),
    .i_cross_tx_axi_data_last(lst),
    .o_mac_tx_port_link(mlink),
    .o_mac_tx_port_speed(mspd),
    .o_mac_tx_axi_data(dout),
    .o_mac_tx_axi_data_keep(kout),
    .o_mac_tx_axi_data_valid(ov),
    .i_mac_tx_axi_data_ready(mrdy),
    .o_mac_tx_axi_data_last(olast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    mrdy = rmode == 0 ? 1'b1 : rmode == 1 ? !mrdy : 1'($urandom_range(0, 1));
  end

  // Reference: a frame starting with link up is forwarded until a beat is taken with link down,
  // which becomes an errored last beat; everything else of that frame is dropped.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mode = 0;
      fwd_bytes = 0;
    end else if (vld && rdy) begin
      if (mode == 0) begin
        mode = link ? 1 : 2;
        if (link && shape_chk) begin
          chk("shape_early", longint'(64 * ((cyc + 2) / 1024) >= fwd_bytes), 1);
          if (fwd_bytes > 0) chk("shape_late", longint'(64 * ((cyc - 4) / 1024) < fwd_bytes), 1);
        end
      end
      if (mode == 1) begin
        sb.push_back({link ? din : {1'b1, din[31:0]}, kin, lst | !link});
        fwd_bytes += $countones(kin);
        mode = lst ? 0 : (link ? 1 : 2);
      end else if (lst) mode = 0;
    end
  end

  always @(posedge clk) begin
    #3;
    if (rst) begin
      eb = 0;
      ef = 0;
      ec = 0;
    end else begin
      if (prst) begin
        chk("rst_valid", ov, 0);
        chk("rst_data", dout, 0);
        chk("rst_keep", kout, 0);
        chk("rst_last", olast, 0);
        chk("rst_bytes", byte_cnt, 0);
        chk("rst_frames", frame_cnt, 0);
        chk("rst_link", mlink, 0);
        chk("rst_speed", mspd, 0);
`ifdef TX_STREAM_CRCERR_CNT_EN
        chk("rst_crcerr", crc_cnt, 0);
`endif
      end else begin
        chk("link_reg", mlink, plink);
        chk("speed_reg", mspd, pspd);
        if (pv && !pm) chk("stall_hold", {ov, dout, kout, olast}, {1'b1, pb});
      end
      chk("valid", ov, sb.size() != 0);
      if (mode == 1) chk("ready_pipe", rdy, !ov | mrdy);
      if (mode == 2) chk("ready_drop", rdy, 1);
      if (ov && mrdy && sb.size() != 0) begin
        mb = sb.pop_front();
        chk("data", dout, mb.d);
        chk("keep", kout, mb.k);
        chk("last", olast, mb.l);
        chk("byte_cnt", byte_cnt, eb);
        chk("frame_cnt", frame_cnt, ef);
        eb += 16'($countones(mb.k));
        ef += 16'(mb.l);
        ec += 16'(mb.l & mb.d[32]);
      end
    end
    prst = rst;
    pv = ov;
    pm = mrdy;
    pb = {dout, kout, olast};
    plink = link;
    pspd = spd;
  end

  task automatic wait_acc();
    int t = 0;
    @(negedge clk);
    while (!rdy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) chk("accept_timeout", rdy, 1);
  endtask

  task automatic send(input int n, input int kf, input int drop_at, input int rst_at, input bit gaps);
    for (int b = 0; b < n; b++) begin
      if (b == rst_at) begin
        vld = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
      end
      while (gaps && $urandom_range(0, 3) == 0) begin
        vld = 0;
        @(posedge clk);
        #1;
      end
      if (b == drop_at) link = 0;
      din = {1'($urandom_range(0, 1)), $urandom()};
      kin = kf < 0 ? 4'($urandom_range(0, 15)) : 4'(kf);
      spd = 2'($urandom_range(0, 3));
      lst = b == n - 1;
      vld = 1;
      wait_acc();
      @(posedge clk);
      #1;
    end
    vld = 0;
    lst = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || ov) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", t < 200, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int n, dn;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    send(16, 15, -1, -1, 0);
    drain();
    chk("t1_bytes", byte_cnt, 64);
    chk("t1_frames", frame_cnt, 1);
    rmode = 1;
    send(3, 15, -1, -1, 0);
    drain();
    chk("t2_bytes", byte_cnt, 76);
    chk("t2_frames", frame_cnt, 2);
    rmode = 0;
    link = 0;
    send(2, 15, -1, -1, 0);
    send(2, 15, -1, -1, 1);
    drain();
    link = 1;
    chk("t4_bytes", byte_cnt, 76);
    chk("t4_frames", frame_cnt, 2);
    send(10, 15, 3, -1, 0);
    link = 1;
    drain();
    chk("t5_bytes", byte_cnt, 92);
    chk("t5_frames", frame_cnt, 3);
    send(6, 15, -1, 3, 0);
    drain();
    chk("t6_bytes", byte_cnt, 12);
    chk("t6_frames", frame_cnt, 1);
    do_reset();
    send(16383, 15, -1, -1, 0);
    send(1, 7, -1, -1, 0);
    drain();
    chk("wrap_pre", byte_cnt, 16'hFFFF);
    send(1, 15, -1, -1, 0);
    drain();
    chk("wrap", byte_cnt, 16'h0003);
    chk("wrap_frames", frame_cnt, 3);
    cfg = 16'h8040;
    do_reset();
    shape_chk = 1;
    for (int f = 0; f < 4; f++) send(32, 15, -1, -1, 0);
    drain();
    chk("shape_bytes", byte_cnt, 512);
    shape_chk = 0;
    cfg = 0;
    rmode = 2;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 12);
      dn = -1;
      if ($urandom_range(0, 7) == 0) link = 0;
      else if (n > 1 && $urandom_range(0, 3) == 0) dn = $urandom_range(1, n - 1);
      send(n, -1, dn, -1, 1);
      link = 1;
    end
    rmode = 0;
    drain();
    chk("final_bytes", byte_cnt, eb);
    chk("final_frames", frame_cnt, ef);
`ifdef TX_STREAM_CRCERR_CNT_EN
    chk("final_crcerr", crc_cnt, ec);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
